// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the 4-digit FND scan path.
package fnd_pkg;
  localparam int FND_DIGITS = 4;
  localparam int FND_SEL_W  = 2;
  localparam int FND_VAL_W  = 14;

  localparam logic [FND_VAL_W-1:0] FND_MAX     = 14'd9999;
  localparam logic [FND_VAL_W-1:0] FND_LZ_TH1  = 14'd10;
  localparam logic [FND_VAL_W-1:0] FND_LZ_TH2  = 14'd100;
  localparam logic [FND_VAL_W-1:0] FND_LZ_TH3  = 14'd1000;

  // Clamp an incoming value to the largest 4-digit decimal number.
  function automatic logic [FND_VAL_W-1:0] fnd_sat(input logic [FND_VAL_W-1:0] v);
    return (v > FND_MAX) ? FND_MAX : v;
  endfunction
endpackage

// File: rtl/fnd_tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
module fnd_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);
  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] pcnt;

  assign tick = (pcnt == W'(DIV - 1));

  // Count 0..DIV-1 and wrap on the tick cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + W'(1);
    end
  end
endmodule

// File: rtl/fnd_scan_scheduler.sv
// Digit-scan sequencer with a frame-synchronous shadow register for the
// displayed value, leading-zero blanking and per-digit blinking.
// Handshake: a value is taken on any cycle where upd_valid && upd_ready;
// upd_ready is low while a taken value waits for the next frame boundary,
// and upd_valid may be held high across not-ready cycles.
module fnd_scan_scheduler
  import fnd_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 125
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 upd_valid,
  output logic                 upd_ready,
  input  logic [FND_VAL_W-1:0] upd_value,
  input  logic                 upd_lz,
  input  logic [FND_DIGITS-1:0] blink_en,
  output logic [FND_SEL_W-1:0] digit_sel,
  output logic [FND_VAL_W-1:0] disp_value,
  output logic                 seg_blank,
  output logic                 frame_start
);
  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int FCW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic                  tick;
  logic                  boundary;
  logic                  accept;
  logic                  pending;
  logic [FND_VAL_W-1:0]  pend_val;
  logic                  pend_lz;
  logic                  lz;
  logic [FND_DIGITS-1:0] bmask;
  logic [FND_DIGITS-1:0] lzb;
  logic [FCW-1:0]        fcnt;
  logic                  phase;

  fnd_tick_gen #(.DIV(DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  assign boundary  = tick && (digit_sel == FND_SEL_W'(FND_DIGITS - 1));
  assign upd_ready = !pending;
  assign accept    = upd_valid && upd_ready;

  // Scan counter and frame pulse; frame_start marks the first digit-0 cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digit_sel   <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= boundary;
      if (tick) digit_sel <= digit_sel + FND_SEL_W'(1);
    end
  end

  // Shadow register: capture on accept, publish only at frame boundaries.
  // An accept can coincide with a boundary only when nothing is pending,
  // so commit and capture never fight over the pending flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending    <= 1'b0;
      pend_val   <= '0;
      pend_lz    <= 1'b0;
      disp_value <= '0;
      lz         <= 1'b0;
    end else begin
      if (boundary && pending) begin
        disp_value <= pend_val;
        lz         <= pend_lz;
        pending    <= 1'b0;
      end
      if (accept) begin
        pend_val <= fnd_sat(upd_value);
        pend_lz  <= upd_lz;
        pending  <= 1'b1;
      end
    end
  end

  // Blink mask sampling and blink phase, both advanced once per frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bmask <= '0;
      fcnt  <= '0;
      phase <= 1'b0;
    end else if (boundary) begin
      bmask <= blink_en;
      if (fcnt == FCW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt <= fcnt + FCW'(1);
      end
    end
  end

  // Leading-zero blank per digit; the ones digit always shows.
  always_comb begin
    lzb    = '0;
    lzb[1] = lz && (disp_value < FND_LZ_TH1);
    lzb[2] = lz && (disp_value < FND_LZ_TH2);
    lzb[3] = lz && (disp_value < FND_LZ_TH3);
  end

  assign seg_blank = lzb[digit_sel] | (bmask[digit_sel] & phase);
endmodule

// File: tb/tb_fnd_scan_scheduler.sv
// Self-checking bench for fnd_scan_scheduler (DIV=4, BLINK_FRAMES=2).
module tb_fnd_scan_scheduler;
  localparam int DIV   = 4;
  localparam int FRAME = 4 * DIV;
  localparam int BF    = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        upd_valid;
  logic        upd_ready;
  logic [13:0] upd_value;
  logic        upd_lz;
  logic [3:0]  blink_en;
  logic [1:0]  digit_sel;
  logic [13:0] disp_value;
  logic        seg_blank;
  logic        frame_start;

  fnd_scan_scheduler #(.CLK_HZ(40), .SCAN_HZ(10), .BLINK_FRAMES(BF)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_value   (upd_value),
    .upd_lz      (upd_lz),
    .blink_en    (blink_en),
    .digit_sel   (digit_sel),
    .disp_value  (disp_value),
    .seg_blank   (seg_blank),
    .frame_start (frame_start)
  );

  // ---------------- scoreboard / model state ----------------
  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [13:0] exp_q[$];      // accepted values awaiting commit, in order
  int          n;             // clock edges since reset released
  logic        m_pending;
  logic [13:0] m_pend_val;
  logic        m_pend_lz;
  logic [13:0] m_disp;
  logic        m_lz;
  logic [3:0]  m_bmask;
  logic        m_commit;
  int          pw[4] = '{1, 10, 100, 1000};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
  endtask

  // Reference: scan position is pure arithmetic on elapsed cycles since reset.
  task automatic model_edge();
    logic bnd, acc;
    m_commit = 1'b0;
    if (!reset_n) begin
      n = 0; m_pending = 0; m_pend_val = 0; m_pend_lz = 0;
      m_disp = 0; m_lz = 0; m_bmask = 0;
      exp_q.delete();
    end else begin
      bnd = ((n % FRAME) == FRAME - 1);
      acc = upd_valid && !m_pending;
      if (bnd) begin
        m_bmask = blink_en;
        if (m_pending) begin
          m_disp = m_pend_val; m_lz = m_pend_lz; m_pending = 0; m_commit = 1'b1;
        end
      end
      if (acc) begin
        m_pend_val = (upd_value > 14'd9999) ? 14'd9999 : upd_value;
        m_pend_lz  = upd_lz;
        m_pending  = 1;
        exp_q.push_back(m_pend_val);
      end
      n++;
    end
  endtask

  task automatic check_outputs();
    int k;
    logic phase, blank;
    logic [13:0] want;
    k     = (n / DIV) % 4;
    phase = ((n / FRAME) / BF) % 2;
    blank = (k > 0 && m_lz && m_disp < pw[k]) || (m_bmask[k] && phase);
    check_eq("digit_sel",   digit_sel,   k);
    check_eq("frame_start", frame_start, (n > 0 && n % FRAME == 0));
    check_eq("upd_ready",   upd_ready,   !m_pending);
    check_eq("disp_value",  disp_value,  m_disp);
    check_eq("seg_blank",   seg_blank,   blank);
    if (m_commit) begin
      want = (exp_q.size() > 0) ? exp_q.pop_front() : 14'h3fff;
      check_eq("commit_order", disp_value, want);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  // Offer a value and hold valid until it is taken (bounded).
  task automatic offer(input logic [13:0] v, input logic lzv);
    int guard;
    upd_value = v; upd_lz = lzv; upd_valid = 1'b1;
    guard = 0;
    while (!upd_ready && guard < 4 * FRAME) begin
      step(); guard++;
    end
    check_eq("offer_timeout", (guard < 4 * FRAME), 1);
    step();
    upd_valid = 1'b0;
  endtask

  task automatic wait_frame();
    int guard;
    guard = 0;
    do begin step(); guard++; end while (!frame_start && guard < 2 * FRAME);
    check_eq("frame_timeout", frame_start, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0; upd_valid = 1'b0; upd_value = '0; upd_lz = 1'b0; blink_en = '0;
    n = 0; m_pending = 0; m_pend_val = 0; m_pend_lz = 0; m_disp = 0; m_lz = 0;
    m_bmask = 0; m_commit = 0;
    run(2);
    reset_n = 1'b1;
    run(40);

    // 1234 offered while digit 1 is being driven
    while (digit_sel != 2'd1) step();
    offer(14'd1234, 1'b0);
    check_eq("ready_after_accept", upd_ready, 0);
    wait_frame();
    check_eq("disp_1234", disp_value, 1234);
    step();
    check_eq("ready_after_commit", upd_ready, 1);

    // back-to-back 5 then 6
    offer(14'd5, 1'b0);
    offer(14'd6, 1'b0);
    wait_frame();
    check_eq("disp_6", disp_value, 6);

    // saturation
    offer(14'd12000, 1'b0);
    wait_frame();
    check_eq("disp_sat", disp_value, 9999);

    // leading-zero blanking
    offer(14'd7, 1'b1);    wait_frame(); run(FRAME);
    offer(14'd0, 1'b1);    wait_frame(); run(FRAME);
    offer(14'd1000, 1'b1); wait_frame(); run(FRAME);

    // blink ones digit
    blink_en = 4'b0001;
    offer(14'd42, 1'b0);
    run(6 * FRAME);
    blink_en = 4'b0000;

    // reset while a value is pending
    run(FRAME);
    while (digit_sel != 2'd1) step();
    offer(14'd55, 1'b0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check_eq("rst_disp", disp_value, 0);
    check_eq("rst_ready", upd_ready, 1);
    run(3 * FRAME);
    check_eq("rst_discard", disp_value, 0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      upd_valid = ($urandom_range(0, 3) == 0);
      upd_value = 14'($urandom_range(0, 16383));
      upd_lz    = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) blink_en = 4'($urandom_range(0, 15));
      reset_n   = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
